// File: rtl/udp_status_reporter_pkg.sv
// Shared definitions for the UDP status reporter: payload layout, fixed length, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   MAGIC_DEFAULT  payload word 0 ("LEDC")
//   UDP_LENGTH     fixed payload length in bytes (4 words x 4 bytes)
//   W_*            payload word indices
//   state_t        reporter FSM states
//   snap_t         counter snapshot carried by one packet
//   sat_inc16      saturating 16-bit increment
package udp_status_reporter_pkg;

   localparam logic [31:0] MAGIC_DEFAULT = 32'h4C454443;
   localparam logic [15:0] UDP_LENGTH    = 16'd16;

   localparam logic [1:0] W_MAGIC  = 2'd0;
   localparam logic [1:0] W_SEQ    = 2'd1;
   localparam logic [1:0] W_FRAME  = 2'd2;
   localparam logic [1:0] W_COUNTS = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] frame_cnt;
      logic [15:0] err_cnt;
      logic [15:0] coal_cnt;
   } snap_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/udp_status_reporter_status_counters.sv
// Event counters, heartbeat timer and the send-request (pending) flag for the status reporter.
// Latency: counters and pending update one cycle after the event pulse.
// Backpressure: none; counting never stalls, requests arriving while one is pending are coalesced.
//
// Ports:
//   clock, reset   system clock, async active-high reset
//   frame_done     1-cycle pulse per completed frame
//   pkt_error      1-cycle pulse per dropped/malformed packet
//   pending_clr    clears pending (asserted while the FSM snapshots the counters)
//   frame_cnt      32b wrapping frame counter
//   err_cnt        16b saturating error counter
//   coal_cnt       16b saturating count of frame triggers merged into an outstanding request
//   pending        a status packet has been requested and not yet snapshotted
module udp_status_reporter_status_counters
   import udp_status_reporter_pkg::*;
#(
   parameter int PERIOD_CYCLES = 25_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_done,
   input  logic        pkt_error,
   input  logic        pending_clr,
   output logic [31:0] frame_cnt,
   output logic [15:0] err_cnt,
   output logic [15:0] coal_cnt,
   output logic        pending
);

   localparam int TIMER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(PERIOD_CYCLES - 1);

   logic [TIMER_W-1:0] timer;
   logic               heartbeat;

   assign heartbeat = (timer == TIMER_MAX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
         coal_cnt  <= '0;
         timer     <= '0;
         pending   <= 1'b0;
      end else begin
         if (frame_done) begin
            frame_cnt <= frame_cnt + 32'd1;
         end
         // Only frame triggers count as coalesced; heartbeats landing on an
         // outstanding request are silently merged.
         if (frame_done && pending) begin
            coal_cnt <= sat_inc16(coal_cnt);
         end
         if (pkt_error) begin
            err_cnt <= sat_inc16(err_cnt);
         end

         // A frame trigger restarts the heartbeat interval.
         if (frame_done || heartbeat) begin
            timer <= '0;
         end else begin
            timer <= timer + TIMER_W'(1);
         end

         // A new request in the snapshot cycle wins over the clear, so an
         // event arriving then still produces a follow-up packet.
         if (frame_done || heartbeat) begin
            pending <= 1'b1;
         end else if (pending_clr) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/udp_status_reporter.sv
// Streams a 4-word UDP status packet (magic, seq, frame count, err/coalesce counts) to the liteeth TX sink.
// Latency: first word valid 2 cycles after a request is pending (IDLE, SNAP); >=1 idle cycle between packets.
// Backpressure: holds data/last while valid & !ready; counters keep running, new requests coalesce.
//
// Ports:
//   clock, reset          system clock, async active-high reset (abandons any packet in flight)
//   frame_done, pkt_error event pulses from the panel writer
//   udp_sink_valid/last   payload word valid / final word of packet
//   udp_sink_ready        TX core accepts the word on valid & ready
//   udp_sink_data         payload word
//   udp_sink_dst_port, udp_sink_ip_address, udp_sink_length, udp_sink_error   constant header fields
module udp_status_reporter
   import udp_status_reporter_pkg::*;
#(
   parameter logic [15:0] DST_PORT      = 16'h1337,
   parameter logic [31:0] DST_IP        = 32'hc0a8b232,
   parameter logic [31:0] MAGIC         = MAGIC_DEFAULT,
   parameter int          PERIOD_CYCLES = 25_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_done,
   input  logic        pkt_error,
   output logic        udp_sink_valid,
   output logic        udp_sink_last,
   input  logic        udp_sink_ready,
   output logic [15:0] udp_sink_dst_port,
   output logic [31:0] udp_sink_ip_address,
   output logic [15:0] udp_sink_length,
   output logic [31:0] udp_sink_data,
   output logic [3:0]  udp_sink_error
);

   logic [31:0] frame_cnt;
   logic [15:0] err_cnt;
   logic [15:0] coal_cnt;
   logic        pending;
   logic        pending_clr;

   state_t      state;
   snap_t       snap;
   logic [31:0] seq;
   logic [1:0]  word_idx;
   logic [1:0]  next_idx;
   logic [31:0] next_word;

   assign udp_sink_dst_port   = DST_PORT;
   assign udp_sink_ip_address = DST_IP;
   assign udp_sink_length     = UDP_LENGTH;
   assign udp_sink_error      = 4'b0000;

   assign pending_clr = (state == ST_SNAP);

   udp_status_reporter_status_counters #(
      .PERIOD_CYCLES (PERIOD_CYCLES)
   ) u_counters (
      .clock       (clock),
      .reset       (reset),
      .frame_done  (frame_done),
      .pkt_error   (pkt_error),
      .pending_clr (pending_clr),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt),
      .coal_cnt    (coal_cnt),
      .pending     (pending)
   );

   // Word presented after the current one is accepted; always sourced from
   // the snapshot so events during SEND cannot alter a packet in flight.
   always_comb begin
      next_idx  = word_idx + 2'd1;
      next_word = MAGIC;
      case (next_idx)
         W_SEQ:    next_word = snap.seq;
         W_FRAME:  next_word = snap.frame_cnt;
         W_COUNTS: next_word = {snap.err_cnt, snap.coal_cnt};
         default:  next_word = MAGIC;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         snap           <= '0;
         seq            <= '0;
         word_idx       <= W_MAGIC;
         udp_sink_valid <= 1'b0;
         udp_sink_last  <= 1'b0;
         udp_sink_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  state <= ST_SNAP;
               end
            end

            ST_SNAP: begin
               snap.seq       <= seq;
               snap.frame_cnt <= frame_cnt;
               snap.err_cnt   <= err_cnt;
               snap.coal_cnt  <= coal_cnt;
               word_idx       <= W_MAGIC;
               udp_sink_valid <= 1'b1;
               udp_sink_last  <= 1'b0;
               udp_sink_data  <= MAGIC;
               state          <= ST_SEND;
            end

            ST_SEND: begin
               if (udp_sink_ready) begin
                  if (word_idx == W_COUNTS) begin
                     udp_sink_valid <= 1'b0;
                     udp_sink_last  <= 1'b0;
                     udp_sink_data  <= '0;
                     seq            <= seq + 32'd1;
                     state          <= ST_IDLE;
                  end else begin
                     word_idx      <= next_idx;
                     udp_sink_data <= next_word;
                     udp_sink_last <= (next_idx == W_COUNTS);
                  end
               end
            end

            default: begin
               udp_sink_valid <= 1'b0;
               udp_sink_last  <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_status_reporter.sv
// Self-checking bench for udp_status_reporter: timeline model plus directed packet checks.
// Latency: model predicts valid/data/last every cycle.
// Backpressure: ready patterns include steady, toggling and long stalls.
module tb_udp_status_reporter;

   localparam int          P     = 100;
   localparam logic [31:0] MAGIC = 32'h4C454443;

   logic        clock;
   logic        reset;
   logic        frame_done;
   logic        pkt_error;
   logic        udp_sink_valid;
   logic        udp_sink_last;
   logic        udp_sink_ready;
   logic [15:0] udp_sink_dst_port;
   logic [31:0] udp_sink_ip_address;
   logic [15:0] udp_sink_length;
   logic [31:0] udp_sink_data;
   logic [3:0]  udp_sink_error;

   int checks = 0;
   int errors = 0;

   logic [32:0] cap_q[$];   // accepted beats {last, data}

   udp_status_reporter #(
      .PERIOD_CYCLES (P)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .frame_done          (frame_done),
      .pkt_error           (pkt_error),
      .udp_sink_valid      (udp_sink_valid),
      .udp_sink_last       (udp_sink_last),
      .udp_sink_ready      (udp_sink_ready),
      .udp_sink_dst_port   (udp_sink_dst_port),
      .udp_sink_ip_address (udp_sink_ip_address),
      .udp_sink_length     (udp_sink_length),
      .udp_sink_data       (udp_sink_data),
      .udp_sink_error      (udp_sink_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   // A request sits one cycle in "snapshot" before the packet becomes visible;
   // the packet is a 4-entry array built from the counters at that moment.
   logic        m_valid, m_snap, m_pend, m_hb;
   int          m_idx, m_timer;
   logic [31:0] m_frame, m_seq;
   logic [15:0] m_err, m_coal;
   logic [31:0] m_pkt [4];

   assign m_hb = (m_timer == P - 1);

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0; m_snap <= 1'b0; m_pend <= 1'b0;
         m_idx <= 0; m_timer <= 0;
         m_frame <= '0; m_seq <= '0; m_err <= '0; m_coal <= '0;
         for (int i = 0; i < 4; i++) m_pkt[i] <= '0;
      end else begin
         if (frame_done) m_frame <= m_frame + 32'd1;
         if (pkt_error && m_err != 16'hFFFF) m_err <= m_err + 16'd1;
         if (frame_done && m_pend && m_coal != 16'hFFFF) m_coal <= m_coal + 16'd1;
         m_timer <= (frame_done || m_hb) ? 0 : m_timer + 1;
         if (frame_done || m_hb) m_pend <= 1'b1;
         else if (m_snap) m_pend <= 1'b0;
         m_snap <= !m_valid && !m_snap && m_pend;
         if (m_snap) begin
            m_pkt[0] <= MAGIC;
            m_pkt[1] <= m_seq;
            m_pkt[2] <= m_frame;
            m_pkt[3] <= {m_err, m_coal};
            m_valid  <= 1'b1;
            m_idx    <= 0;
         end else if (m_valid && udp_sink_ready) begin
            if (m_idx == 3) begin
               m_valid <= 1'b0;
               m_seq   <= m_seq + 32'd1;
            end else begin
               m_idx <= m_idx + 1;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   logic        stall_prev = 1'b0;
   logic [32:0] stall_val  = '0;

   always @(negedge clock) begin
      check("valid", 64'(udp_sink_valid), 64'(m_valid));
      if (m_valid) begin
         check("data", 64'(udp_sink_data), 64'(m_pkt[m_idx]));
         check("last", 64'(udp_sink_last), 64'(m_idx == 3));
      end
      if (stall_prev && !reset) begin
         check("stall_hold", 64'({udp_sink_valid, udp_sink_last, udp_sink_data}),
               64'({1'b1, stall_val}));
      end
      stall_prev <= udp_sink_valid && !udp_sink_ready && !reset;
      stall_val  <= {udp_sink_last, udp_sink_data};
      if (udp_sink_valid && udp_sink_ready && !reset) cap_q.push_back({udp_sink_last, udp_sink_data});
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_frame();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic pulse_err();
      pkt_error = 1'b1;
      tick();
      pkt_error = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      cap_q.delete();
   endtask

   task automatic wait_beats(input int n, input int budget, input string name);
      int c;
      c = 0;
      while (cap_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      check(name, 64'(cap_q.size()), 64'(n));
   endtask

   task automatic wait_valid(input int budget, input string name);
      int c;
      c = 0;
      while (!udp_sink_valid && c < budget) begin
         tick();
         c++;
      end
      check(name, 64'(udp_sink_valid), 64'd1);
   endtask

   task automatic check_pkt(input int base, input string name,
                            input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
      logic [32:0] exp [4];
      exp[0] = {1'b0, MAGIC};
      exp[1] = {1'b0, w1};
      exp[2] = {1'b0, w2};
      exp[3] = {1'b1, w3};
      for (int i = 0; i < 4; i++) begin
         if (base + i < cap_q.size())
            check($sformatf("%s_w%0d", name, i), 64'(cap_q[base + i]), 64'(exp[i]));
         else
            check($sformatf("%s_w%0d_missing", name, i), 64'(cap_q.size()), 64'(base + i + 1));
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      reset = 1'b1;
      frame_done = 1'b0;
      pkt_error = 1'b0;
      udp_sink_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid", 64'(udp_sink_valid), 64'd0);
      check("rst_last", 64'(udp_sink_last), 64'd0);
      check("rst_data", 64'(udp_sink_data), 64'd0);
      check("dst_port", 64'(udp_sink_dst_port), 64'h1337);
      check("ip_addr", 64'(udp_sink_ip_address), 64'hc0a8b232);
      check("length", 64'(udp_sink_length), 64'd16);
      check("error_tie", 64'(udp_sink_error), 64'd0);
      reset = 1'b0;
      cap_q.delete();

      // Single frame, ready always high; first valid two cycles after pending.
      tick();
      tick();
      pulse_frame();
      check("lat_idle", 64'(udp_sink_valid), 64'd0);
      tick();
      check("lat_snap", 64'(udp_sink_valid), 64'd0);
      tick();
      check("lat_first", 64'(udp_sink_valid), 64'd1);
      wait_beats(4, 20, "t1_beats");
      check_pkt(0, "t1", 32'd0, 32'd1, 32'h0000_0000);

      // Errors (one coincident with a frame) then frames.
      do_reset();
      pulse_err();
      pulse_err();
      frame_done = 1'b1;
      pkt_error  = 1'b1;
      tick();
      frame_done = 1'b0;
      pkt_error  = 1'b0;
      wait_beats(4, 20, "t2_beats_a");
      check_pkt(0, "t2a", 32'd0, 32'd1, 32'h0003_0000);
      pulse_frame();
      wait_beats(8, 20, "t2_beats_b");
      check_pkt(4, "t2b", 32'd1, 32'd2, 32'h0003_0000);

      // Ready toggling every cycle: exactly one packet of 4 beats.
      do_reset();
      pulse_frame();
      for (int i = 0; i < 30; i++) begin
         udp_sink_ready = ~udp_sink_ready;
         tick();
      end
      udp_sink_ready = 1'b1;
      tick();
      check("t3_beats", 64'(cap_q.size()), 64'd4);
      check_pkt(0, "t3", 32'd0, 32'd1, 32'h0000_0000);

      // Heartbeat only: three packets, sequence counting up, no frames.
      do_reset();
      wait_beats(12, 400, "t4_beats");
      check_pkt(0, "t4a", 32'd0, 32'd0, 32'h0000_0000);
      check_pkt(4, "t4b", 32'd1, 32'd0, 32'h0000_0000);
      check_pkt(8, "t4c", 32'd2, 32'd0, 32'h0000_0000);

      // Frames during a stall coalesce into one follow-up packet.
      do_reset();
      udp_sink_ready = 1'b0;
      pulse_frame();
      wait_valid(10, "t5_valid");
      for (int i = 0; i < 3; i++) begin
         pulse_frame();
         tick();
      end
      tick();
      check("t5_stalled", 64'(cap_q.size()), 64'd0);
      udp_sink_ready = 1'b1;
      wait_beats(8, 40, "t5_beats");
      check_pkt(0, "t5a", 32'd0, 32'd1, 32'h0000_0000);
      check_pkt(4, "t5b", 32'd1, 32'd4, 32'h0000_0002);

      // Reset while beat 2 is presented.
      do_reset();
      pulse_frame();
      wait_valid(10, "t6_valid");
      tick();
      check("t6_beat2_valid", 64'(udp_sink_valid), 64'd1);
      check("t6_beat2_data", 64'(udp_sink_data), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_valid", 64'(udp_sink_valid), 64'd0);
      check("t6_rst_data", 64'(udp_sink_data), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      cap_q.delete();
      repeat (8) tick();
      check("t6_no_resend", 64'(cap_q.size()), 64'd0);
      pulse_frame();
      wait_beats(4, 20, "t6_beats");
      check_pkt(0, "t6", 32'd0, 32'd1, 32'h0000_0000);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
